// File: rtl/sha_msg_schedule.sv
// SHA-2 message-schedule expander: loads a 16-word block, then streams W_0..W_{ROUNDS-1}.
// Define MSG_SCHED_PIPE_EN to drive out_data/out_idx/out_last from a one-entry output stage.
module sha_msg_schedule #(
  parameter int WORD_W = 64,
  parameter int ROUNDS = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [6:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam logic [6:0]  LAST_T = 7'(ROUNDS - 1);
  localparam int unsigned S0_A = (WORD_W == 64) ? 32'd1  : 32'd7;
  localparam int unsigned S0_B = (WORD_W == 64) ? 32'd8  : 32'd18;
  localparam int unsigned S0_C = (WORD_W == 64) ? 32'd7  : 32'd3;
  localparam int unsigned S1_A = (WORD_W == 64) ? 32'd19 : 32'd17;
  localparam int unsigned S1_B = (WORD_W == 64) ? 32'd61 : 32'd19;
  localparam int unsigned S1_C = (WORD_W == 64) ? 32'd6  : 32'd10;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
  endfunction

  state_t            state, state_nxt;
  logic [3:0]        ld_cnt;
  logic [6:0]        t;
  logic [WORD_W-1:0] wbuf [16];
  logic [3:0]        ti;
  logic [WORD_W-1:0] w_calc;
  logic              ld_fire, ld_last, issue, done;

  assign ti       = t[3:0];
  assign ld_fire  = (state == LOAD) && in_valid;
  assign ld_last  = ld_fire && (ld_cnt == 4'd15);
  assign in_ready = (state == LOAD);
  assign busy     = (state == RUN);

  // Schedule word for index t; the ring slot ti still holds W_{t-16} when t >= 16
  always_comb begin
    w_calc = '0;
    if (t < 7'd16) begin
      w_calc = wbuf[ti];
    end else begin
      w_calc = sig1(wbuf[ti - 4'd2]) + wbuf[ti - 4'd7] + sig0(wbuf[ti - 4'd15]) + wbuf[ti];
    end
  end

`ifdef MSG_SCHED_PIPE_EN
  logic              issued_all, stg_valid, stg_last;
  logic [WORD_W-1:0] stg_data;
  logic [6:0]        stg_idx;

  assign issue = busy && !issued_all && (!stg_valid || out_ready);
  assign done  = stg_valid && out_ready && stg_last;

  // Output stage; slot ti is written back as the word enters, so later reads see it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid  <= 1'b0;
      stg_data   <= '0;
      stg_idx    <= 7'd0;
      stg_last   <= 1'b0;
      issued_all <= 1'b0;
    end else begin
      if (issue) begin
        stg_valid <= 1'b1;
        stg_data  <= w_calc;
        stg_idx   <= t;
        stg_last  <= (t == LAST_T);
      end else if (out_ready) begin
        stg_valid <= 1'b0;
        stg_data  <= '0;
        stg_idx   <= 7'd0;
        stg_last  <= 1'b0;
      end
      if (issue && (t == LAST_T)) begin
        issued_all <= 1'b1;
      end else if (done) begin
        issued_all <= 1'b0;
      end
    end
  end

  assign out_valid = stg_valid;
  assign out_data  = stg_data;
  assign out_idx   = stg_idx;
  assign out_last  = stg_last;
`else
  assign issue     = busy && out_ready;
  assign done      = issue && (t == LAST_T);
  assign out_valid = busy;
  assign out_data  = busy ? w_calc : '0;
  assign out_idx   = busy ? t : 7'd0;
  assign out_last  = busy && (t == LAST_T);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (ld_last) state_nxt = RUN;
        else         state_nxt = LOAD;
      end
      RUN: begin
        if (done) state_nxt = LOAD;
        else      state_nxt = RUN;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Ring buffer, load counter and round index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt <= 4'd0;
      t      <= 7'd0;
      for (int i = 0; i < 16; i++) wbuf[i] <= '0;
    end else begin
      if (ld_fire) begin
        wbuf[ld_cnt] <= in_data;
        ld_cnt       <= ld_cnt + 4'd1;
      end
      if (issue && (t >= 7'd16)) begin
        wbuf[ti] <= w_calc;
      end
      if (ld_last) begin
        t <= 7'd0;
      end else if (issue) begin
        t <= (t == LAST_T) ? 7'd0 : t + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule: SHA-256/512 "abc" schedules, backpressure, back-to-back, mid-run reset.
module tb_sha_msg_schedule;

`ifdef MSG_SCHED_PIPE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct {
    int          idx;
    logic [63:0] w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, sel32;
  logic [63:0] in_data;

  logic        in_ready32, out_valid32, out_last32, busy32;
  logic [31:0] out_data32;
  logic [6:0]  out_idx32;
  logic        in_ready64, out_valid64, out_last64, busy64;
  logic [63:0] out_data64;
  logic [6:0]  out_idx64;

  logic        in_ready_v, out_valid_v, out_last_v, busy_v;
  logic [63:0] out_data_v;
  logic [6:0]  out_idx_v;

  int          n_pass = 0, n_tot = 0;
  logic [63:0] msg [16];
  logic [63:0] exp_w [80];
  logic [63:0] got_w [80];
  logic [63:0] ref_w [80];
  logic [6:0]  got_i [80];
  logic        got_l [80];
  int          n_got, lat;
  vec_t        t256 [6];
  vec_t        t512 [6];
  bit          stopped;
  int          pre_acc;

  always #5 clk = ~clk;

  sha_msg_schedule #(.WORD_W(32), .ROUNDS(64)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel32), .in_ready(in_ready32),
    .in_data(in_data[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
    .out_data(out_data32), .out_idx(out_idx32), .out_last(out_last32), .busy(busy32)
  );

  sha_msg_schedule #(.WORD_W(64), .ROUNDS(80)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel32), .in_ready(in_ready64),
    .in_data(in_data), .out_valid(out_valid64), .out_ready(out_ready),
    .out_data(out_data64), .out_idx(out_idx64), .out_last(out_last64), .busy(busy64)
  );

  assign in_ready_v  = sel32 ? in_ready32  : in_ready64;
  assign out_valid_v = sel32 ? out_valid32 : out_valid64;
  assign out_last_v  = sel32 ? out_last32  : out_last64;
  assign busy_v      = sel32 ? busy32      : busy64;
  assign out_data_v  = sel32 ? {32'd0, out_data32} : out_data64;
  assign out_idx_v   = sel32 ? out_idx32   : out_idx64;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  // Reference sigmas written with explicit bit-slice rotations (FIPS 180-4)
  function automatic logic [63:0] ref_s0(input logic [63:0] x, input bit narrow);
    logic [31:0] y;
    y = x[31:0];
    if (narrow) return {32'd0, {y[6:0], y[31:7]} ^ {y[17:0], y[31:18]} ^ (y >> 3)};
    else        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ref_s1(input logic [63:0] x, input bit narrow);
    logic [31:0] y;
    y = x[31:0];
    if (narrow) return {32'd0, {y[16:0], y[31:17]} ^ {y[18:0], y[31:19]} ^ (y >> 10)};
    else        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  task automatic build_model(input bit narrow, input int rounds);
    logic [63:0] s;
    for (int k = 0; k < rounds; k++) begin
      if (k < 16) begin
        exp_w[k] = msg[k];
      end else begin
        s = ref_s1(exp_w[k-2], narrow) + exp_w[k-7] + ref_s0(exp_w[k-15], narrow) + exp_w[k-16];
        exp_w[k] = narrow ? (s & 64'h0000_0000_FFFF_FFFF) : s;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  {63'd0, in_ready_v},  64'd1);
    chk({tag, "_out_valid"}, {63'd0, out_valid_v}, 64'd0);
    chk({tag, "_out_data"},  out_data_v,           64'd0);
    chk({tag, "_out_idx"},   {57'd0, out_idx_v},   64'd0);
    chk({tag, "_out_last"},  {63'd0, out_last_v},  64'd0);
    chk({tag, "_busy"},      {63'd0, busy_v},      64'd0);
  endtask

  task automatic load_block(input int start);
    int i = start;
    int cyc = 0;
    while (i < 16) begin
      @(negedge clk);
      cyc++;
      if (cyc > 200) begin
        chk("load_timeout", 64'(i), 64'd16);
        break;
      end
      in_valid = 1'b1;
      in_data  = msg[i];
      if (in_ready_v) i++;
    end
  endtask

  task automatic run_block(input int rounds, input bit rand_ready, input bit hold,
                           input logic [63:0] hold_word, input int stop_at,
                           output bit stop_hit, output int pre);
    int          cyc = 0;
    bit          prev_stall = 1'b0;
    bit          seen = 1'b0;
    logic [63:0] pd;
    logic [6:0]  pi;
    logic        pl;
    n_got = 0; lat = 0; stop_hit = 1'b0; pre = 0;
    pd = '0; pi = '0; pl = 1'b0;
    while (n_got < rounds) begin
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        chk("run_timeout", 64'(n_got), 64'(rounds));
        break;
      end
      if (hold) begin
        in_valid = 1'b1;
        in_data  = hold_word;
        chk("in_ready_run", {63'd0, in_ready_v}, 64'd0);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        chk("stall_data", out_data_v, pd);
        chk("stall_idx",  {57'd0, out_idx_v}, {57'd0, pi});
        chk("stall_last", {63'd0, out_last_v}, {63'd0, pl});
      end
      if (out_valid_v && !seen) begin
        seen = 1'b1;
        lat  = cyc;
      end
      if (stop_at >= 0 && out_valid_v && out_idx_v == 7'(stop_at)) begin
        stop_hit = 1'b1;
        break;
      end
      if (out_valid_v && out_ready) begin
        got_w[n_got] = out_data_v;
        got_i[n_got] = out_idx_v;
        got_l[n_got] = out_last_v;
        n_got++;
      end
      prev_stall = out_valid_v && !out_ready;
      pd = out_data_v; pi = out_idx_v; pl = out_last_v;
    end
    if (!stop_hit && n_got == rounds) begin
      @(negedge clk);
      chk("post_in_ready",  {63'd0, in_ready_v},  64'd1);
      chk("post_out_valid", {63'd0, out_valid_v}, 64'd0);
      chk("post_busy",      {63'd0, busy_v},      64'd0);
      if (hold && in_ready_v) pre = 1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic verify_block(input string tag, input int rounds);
    chk({tag, "_count"},   64'(n_got), 64'(rounds));
    chk({tag, "_latency"}, 64'(lat),   64'(EXP_LAT));
    for (int k = 0; k < n_got; k++) begin
      chk($sformatf("%s_w[%0d]", tag, k),    got_w[k], exp_w[k]);
      chk($sformatf("%s_idx[%0d]", tag, k),  {57'd0, got_i[k]}, 64'(k));
      chk($sformatf("%s_last[%0d]", tag, k), {63'd0, got_l[k]}, {63'd0, (k == rounds - 1)});
    end
  endtask

  task automatic set_abc(input bit narrow);
    for (int k = 0; k < 16; k++) msg[k] = 64'd0;
    msg[0]  = narrow ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
    msg[15] = 64'h0000_0000_0000_0018;
  endtask

  initial begin
    t256[0] = '{16, 64'h0000_0000_6162_6380};
    t256[1] = '{17, 64'h0000_0000_000F_0000};
    t256[2] = '{18, 64'h0000_0000_7DA8_6405};
    t256[3] = '{19, 64'h0000_0000_6000_03C6};
    t256[4] = '{0,  64'h0000_0000_6162_6380};
    t256[5] = '{15, 64'h0000_0000_0000_0018};
    t512[0] = '{0,  64'h6162_6380_0000_0000};
    t512[1] = '{1,  64'h0000_0000_0000_0000};
    t512[2] = '{14, 64'h0000_0000_0000_0000};
    t512[3] = '{15, 64'h0000_0000_0000_0018};
    t512[4] = '{16, 64'h6162_6380_0000_0000};
    t512[5] = '{17, 64'h0003_0000_0000_00C0};

    rst = 1'b1; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0; sel32 = 1'b0;
    #2;
    chk_reset("rst64");
    sel32 = 1'b1;
    #1;
    chk_reset("rst32");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // SHA-256 "abc"
    sel32 = 1'b1;
    set_abc(1'b1);
    build_model(1'b1, 64);
    load_block(0);
    run_block(64, 1'b0, 1'b0, 64'd0, -1, stopped, pre_acc);
    verify_block("s256", 64);
    for (int k = 0; k < 6; k++)
      chk($sformatf("tbl256_w[%0d]", t256[k].idx), got_w[t256[k].idx], t256[k].w);

    // SHA-512 "abc", full ready
    sel32 = 1'b0;
    set_abc(1'b0);
    build_model(1'b0, 80);
    load_block(0);
    run_block(80, 1'b0, 1'b0, 64'd0, -1, stopped, pre_acc);
    verify_block("s512", 80);
    for (int k = 0; k < 6; k++)
      chk($sformatf("tbl512_w[%0d]", t512[k].idx), got_w[t512[k].idx], t512[k].w);
    for (int k = 0; k < 80; k++) ref_w[k] = got_w[k];

    // SHA-512 "abc", random backpressure
    load_block(0);
    run_block(80, 1'b1, 1'b0, 64'd0, -1, stopped, pre_acc);
    verify_block("rnd", 80);
    for (int k = 0; k < n_got; k++)
      chk($sformatf("rnd_vs_full[%0d]", k), got_w[k], ref_w[k]);

    // Back-to-back: all-ones block offered throughout RUN
    load_block(0);
    run_block(80, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, -1, stopped, pre_acc);
    verify_block("b2b_a", 80);
    chk("b2b_first_accept", 64'(pre_acc), 64'd1);
    for (int k = 0; k < 16; k++) msg[k] = 64'hFFFF_FFFF_FFFF_FFFF;
    build_model(1'b0, 80);
    load_block(pre_acc);
    run_block(80, 1'b0, 1'b0, 64'd0, -1, stopped, pre_acc);
    verify_block("b2b_b", 80);

    // Reset mid-RUN at out_idx 40, then a fresh block
    set_abc(1'b0);
    build_model(1'b0, 80);
    load_block(0);
    run_block(80, 1'b0, 1'b0, 64'd0, 40, stopped, pre_acc);
    chk("stop_at_40", {63'd0, stopped}, 64'd1);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    load_block(0);
    run_block(80, 1'b0, 1'b0, 64'd0, -1, stopped, pre_acc);
    verify_block("after_rst", 80);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sha_msg_schedule.md
# sha_msg_schedule

Parametrised SHA-2 message-schedule expander, the sequential successor to the combinational small-sigma blocks. It accepts one 16-word message block over a valid/ready input, then streams the full schedule W_0..W_{ROUNDS-1} over a valid/ready output. It sits between the padding/block-formatter and the compression round datapath. One instance serves SHA-256 (WORD_W=32) or SHA-512 (WORD_W=64), with σ0 and σ1 computed internally.

## Interface
- WORD_W, 64, word width; legal values 32 (SHA-256 constants) and 64 (SHA-512 constants).
- ROUNDS, 80, schedule length; 64 for SHA-256, 80 for SHA-512; legal range 16..80.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  message word valid.
- in_ready  output  1  block can accept a message word.
- in_data  input  WORD_W  message word, M_0 first.
- out_valid  output  1  schedule word valid.
- out_ready  input  1  consumer accepts schedule word.
- out_data  output  WORD_W  schedule word W_t.
- out_idx  output  7  t of the current out_data.
- out_last  output  1  high with out_valid when t = ROUNDS-1.
- busy  output  1  high in RUN state.

## Operation
- The block stores words in a 16-entry circular buffer buf[0..15], indexed by t mod 16.
- The state machine has two states, LOAD and RUN. Reset enters LOAD.
- LOAD:
  - in_ready=1, out_valid=0.
  - Each in_valid&&in_ready writes buf[ld_cnt] and increments ld_cnt, a 4-bit counter.
  - The handshake with ld_cnt=15 moves to RUN, clears t to 0, and wraps ld_cnt to 0.
- RUN:
  - in_ready=0, out_valid=1.
  - For t<16: out_data=buf[t].
  - For t≥16: out_data = σ1(buf[(t-2)&15]) + buf[(t-7)&15] + σ0(buf[(t-15)&15]) + buf[t&15], modulo 2^WORD_W (carries discarded).
  - On out_valid&&out_ready with t≥16, out_data is written into buf[t&15]. This overwrites W_{t-16}, which is no longer needed.
  - Each output handshake increments t.
  - The handshake at t=ROUNDS-1 returns the block to LOAD.
- Sigma functions (ROTR = rotate right, SHR = logical shift right):
  - WORD_W=64: σ0 = ROTR1^ROTR8^SHR7 and σ1 = ROTR19^ROTR61^SHR6.
  - WORD_W=32: σ0 = ROTR7^ROTR18^SHR3 and σ1 = ROTR17^ROTR19^SHR10.
- out_idx=t and out_last=(t==ROUNDS-1), both qualified by out_valid (0 otherwise).
- Input words presented in RUN are ignored (in_ready=0). There is no partial-block abort; only rst discards a block.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, ld_cnt=0, t=0.
- Assertion of rst mid-LOAD or mid-RUN clears all state immediately and discards the block. The first cycle after deassertion accepts M_0.
- Latency: when M_15 is accepted on edge k, out_valid=1 with W_0 in the cycle after k (one cycle, base build).
- Throughput is one word per cycle in both directions under full ready.
- A full block occupies 16 + ROUNDS cycles minimum. There is no overlap of LOAD with RUN.
- Output backpressure: while out_valid&&!out_ready, out_data, out_idx and out_last hold stable. The buffer and t do not change.
- Input backpressure is not applicable; in_ready does not depend on in_valid.

## Configuration
- MSG_SCHED_PIPE_EN defined:
  - A one-entry output register stage is inserted after the compute path. out_data, out_idx and out_last are driven from flops.
  - The stage loads when empty or when out_ready=1, so throughput stays one word per cycle.
  - The buffer write-back for t≥16 occurs when the word enters the stage, not when it leaves.
  - LOAD→first out_valid latency becomes 2 cycles.
  - The return to LOAD waits until W_{ROUNDS-1} leaves the stage.
  - The stage is cleared by rst.
- MSG_SCHED_PIPE_EN undefined: out_data is combinational from the buffer as described above, with 1-cycle latency.

## Test plan
- SHA-256 "abc" block (WORD_W=32, ROUNDS=64): M_0=0x61626380, M_1..M_14=0, M_15=0x00000018, out_ready=1.
  - Required: W_16=0x61626380, W_17=0x000F0000, W_18=0x7DA86405, W_19=0x600003C6.
  - Required: exactly 64 outputs, with out_last only at out_idx=63.
- SHA-512 "abc" block (defaults): M_0=0x6162638000000000, M_15=0x18, others 0.
  - Required: W_0..W_15 echo the input; W_16=0x6162638000000000, W_17=0x00030000000000C0.
  - Required: 80 outputs, with out_last at out_idx=79.
- Random out_ready (50%) on the SHA-512 "abc" block: the output sequence is identical to the full-ready run, and out_data/out_idx are stable during every stalled cycle.
- Back-to-back blocks: a second block (all M=0xFFFF...F) is offered with in_valid held high through RUN. No words are accepted during RUN, in_ready rises the cycle after the W_79 handshake, and the second schedule is correct.
- rst pulsed at out_idx=40: all outputs return to reset values asynchronously. The block then accepts a fresh 16-word block and restarts at out_idx=0 with the correct W values.
- Run each of the above with and without MSG_SCHED_PIPE_EN: identical word streams are required, with first-output latency of 1 and 2 cycles respectively.
